// File: rtl/phys_free_list.sv
// phys_free_list: circular free-list of unmapped physical tags for Rename.
// Pops one tag per cycle and reclaims up to two retired tags per cycle.
// Optional feature: define FREELIST_BYPASS_EN to forward freed_tag_1 straight
// to the requester when the list is empty.
module phys_free_list #(
  parameter int unsigned TAG_W    = 6,
  parameter int unsigned NUM_ARCH = 32,
  parameter int unsigned DEPTH    = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             alloc_req,
  output logic                             alloc_valid,
  output logic [TAG_W-1:0]                 alloc_tag,
  input  logic [TAG_W-1:0]                 freed_tag_1,
  input  logic [TAG_W-1:0]                 freed_tag_2,
  output logic [$clog2(DEPTH+1)-1:0]       free_count,
  output logic                             overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             overflow_q;

  logic             fifo_nonempty_c;
  logic             pop_c;
  logic             byp_take_c;
  logic             push1_req_c;
  logic             push2_req_c;
  logic             push1_ok_c;
  logic             push2_ok_c;
  logic             drop_c;
  logic [CNT_W-1:0] cap_c;
  logic [CNT_W-1:0] push_n_c;
  logic [PTR_W-1:0] wr_idx2_c;

  // Grant selection, push capacity and drop decisions for this cycle.
  always_comb begin
    fifo_nonempty_c = (count != '0);
    pop_c           = alloc_req && fifo_nonempty_c;
`ifdef FREELIST_BYPASS_EN
    byp_take_c  = !fifo_nonempty_c && (freed_tag_1 != '0) && alloc_req;
    alloc_valid = fifo_nonempty_c || (freed_tag_1 != '0);
    alloc_tag   = fifo_nonempty_c ? mem[head] : freed_tag_1;
`else
    byp_take_c  = 1'b0;
    alloc_valid = fifo_nonempty_c;
    alloc_tag   = mem[head];
`endif
    // A bypassed freed_tag_1 is consumed and never enters the list.
    push1_req_c = (freed_tag_1 != '0) && !byp_take_c;
    push2_req_c = (freed_tag_2 != '0);
    // A pop this cycle frees one slot for the incoming pushes.
    cap_c       = CNT_W'(DEPTH) - count + CNT_W'(pop_c);
    // freed_tag_1 has priority; freed_tag_2 is the first to be dropped.
    push1_ok_c  = push1_req_c && (cap_c != '0);
    push2_ok_c  = push2_req_c && (cap_c > (push1_ok_c ? CNT_W'(1) : CNT_W'(0)));
    drop_c      = (push1_req_c && !push1_ok_c) || (push2_req_c && !push2_ok_c);
    push_n_c    = CNT_W'(push1_ok_c) + CNT_W'(push2_ok_c);
    wr_idx2_c   = tail + PTR_W'(push1_ok_c);
  end

  // Storage, pointers, occupancy and sticky overflow; reset loads the
  // unmapped tags NUM_ARCH..NUM_ARCH+DEPTH-1 in order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[PTR_W'(i)] <= TAG_W'(NUM_ARCH + i);
      end
      head       <= '0;
      tail       <= '0;
      count      <= CNT_W'(DEPTH);
      overflow_q <= 1'b0;
    end else begin
      if (push1_ok_c) mem[tail]      <= freed_tag_1;
      if (push2_ok_c) mem[wr_idx2_c] <= freed_tag_2;
      if (pop_c)      head           <= head + PTR_W'(1);
      tail  <= tail + PTR_W'(push_n_c);
      count <= count - CNT_W'(pop_c) + push_n_c;
      if (drop_c) overflow_q <= 1'b1;
    end
  end

  assign free_count = count;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_phys_free_list.sv
// Self-checking bench for phys_free_list: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_phys_free_list;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       alloc_req = 1'b0;
  logic       alloc_valid;
  logic [5:0] alloc_tag;
  logic [5:0] freed_tag_1 = '0;
  logic [5:0] freed_tag_2 = '0;
  logic [5:0] free_count;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: list contents in allocation order, plus sticky flag.
  logic [5:0] mq[$];
  logic       movf = 1'b0;
  bit         known = 1'b0;

  phys_free_list dut (
    .clk         (clk),
    .reset       (reset),
    .alloc_req   (alloc_req),
    .alloc_valid (alloc_valid),
    .alloc_tag   (alloc_tag),
    .freed_tag_1 (freed_tag_1),
    .freed_tag_2 (freed_tag_2),
    .free_count  (free_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample outputs, check against the model,
  // then advance the model by the rules of the allocator.
  task automatic cyc(input logic rq, input logic [5:0] f1, input logic [5:0] f2,
                     input logic rs, output logic v, output logic [5:0] t,
                     output logic [5:0] fc, output logic ov);
    logic       exp_v;
    logic [5:0] exp_t;
    bit         byp;
    @(negedge clk);
    alloc_req   = rq;
    freed_tag_1 = f1;
    freed_tag_2 = f2;
    reset       = rs;
    #1;
    v  = alloc_valid;
    t  = alloc_tag;
    fc = free_count;
    ov = overflow;
    byp = 1'b0;
`ifdef FREELIST_BYPASS_EN
    byp = (mq.size() == 0) && (f1 != 0);
`endif
    exp_v = (mq.size() != 0) || byp;
    exp_t = (mq.size() != 0) ? mq[0] : f1;
    if (known) begin
      lit("alloc_valid", 32'(v), 32'(exp_v));
      if (exp_v) lit("alloc_tag", 32'(t), 32'(exp_t));
      lit("free_count", 32'(fc), 32'(mq.size()));
      lit("overflow", 32'(ov), 32'(movf));
    end
    if (!rs) begin
      mq.delete();
      for (int i = 0; i < 32; i++) mq.push_back(6'(32 + i));
      movf  = 1'b0;
      known = 1'b1;
    end else begin
      if (rq && mq.size() != 0) void'(mq.pop_front());
      if (f1 != 0 && !(byp && rq)) begin
        if (mq.size() < 32) mq.push_back(f1); else movf = 1'b1;
      end
      if (f2 != 0) begin
        if (mq.size() < 32) mq.push_back(f2); else movf = 1'b1;
      end
    end
  endtask

  initial begin
    logic       v, ov;
    logic [5:0] t, fc;

    // Reset and post-reset image.
    cyc(1'b0, 6'd0, 6'd0, 1'b0, v, t, fc, ov);
    cyc(1'b0, 6'd0, 6'd0, 1'b0, v, t, fc, ov);
    cyc(1'b0, 6'd0, 6'd0, 1'b1, v, t, fc, ov);
    lit("rst_valid", 32'(v), 32'd1);
    lit("rst_tag", 32'(t), 32'd32);
    lit("rst_count", 32'(fc), 32'd32);
    lit("rst_overflow", 32'(ov), 32'd0);

    // Drain: tags 32..63 in order, then stall on empty.
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, 6'd0, 6'd0, 1'b1, v, t, fc, ov);
      lit("drain_tag", 32'(t), 32'(32 + i));
    end
    cyc(1'b1, 6'd0, 6'd0, 1'b1, v, t, fc, ov);
    lit("empty_valid", 32'(v), 32'd0);
    lit("empty_count", 32'(fc), 32'd0);

    // Free (40,7) from empty, allocate both back.
    cyc(1'b0, 6'd40, 6'd7, 1'b1, v, t, fc, ov);
    cyc(1'b1, 6'd0, 6'd0, 1'b1, v, t, fc, ov);
    lit("pair_count", 32'(fc), 32'd2);
    lit("pair_first", 32'(t), 32'd40);
    cyc(1'b1, 6'd0, 6'd0, 1'b1, v, t, fc, ov);
    lit("pair_second", 32'(t), 32'd7);

    // Free through freed_tag_2 only.
    cyc(1'b0, 6'd0, 6'd5, 1'b1, v, t, fc, ov);
    cyc(1'b1, 6'd0, 6'd0, 1'b1, v, t, fc, ov);
    lit("f2_count", 32'(fc), 32'd1);
    lit("f2_tag", 32'(t), 32'd5);

    // count==1 with simultaneous pop and double push.
    cyc(1'b0, 6'd50, 6'd0, 1'b1, v, t, fc, ov);
    cyc(1'b1, 6'd9, 6'd12, 1'b1, v, t, fc, ov);
    lit("one_tag", 32'(t), 32'd50);
    cyc(1'b1, 6'd0, 6'd0, 1'b1, v, t, fc, ov);
    lit("one_count", 32'(fc), 32'd2);
    lit("one_next", 32'(t), 32'd9);
    cyc(1'b1, 6'd0, 6'd0, 1'b1, v, t, fc, ov);
    lit("one_last", 32'(t), 32'd12);

    // Empty list, alloc plus free (33,34) in the same cycle.
    cyc(1'b1, 6'd33, 6'd34, 1'b1, v, t, fc, ov);
`ifdef FREELIST_BYPASS_EN
    lit("byp_valid", 32'(v), 32'd1);
    lit("byp_tag", 32'(t), 32'd33);
    cyc(1'b0, 6'd0, 6'd0, 1'b1, v, t, fc, ov);
    lit("byp_count", 32'(fc), 32'd1);
`else
    lit("nobyp_valid", 32'(v), 32'd0);
    cyc(1'b0, 6'd0, 6'd0, 1'b1, v, t, fc, ov);
    lit("nobyp_count", 32'(fc), 32'd2);
`endif

    // Full list: both frees dropped without an alloc.
    cyc(1'b0, 6'd0, 6'd0, 1'b0, v, t, fc, ov);
    cyc(1'b0, 6'd20, 6'd21, 1'b1, v, t, fc, ov);
    lit("full_pre_ovf", 32'(ov), 32'd0);
    cyc(1'b0, 6'd0, 6'd0, 1'b1, v, t, fc, ov);
    lit("full_ovf", 32'(ov), 32'd1);
    lit("full_count", 32'(fc), 32'd32);

    // Full list with alloc: 20 kept behind the rest, 21 dropped.
    cyc(1'b0, 6'd0, 6'd0, 1'b0, v, t, fc, ov);
    cyc(1'b1, 6'd20, 6'd21, 1'b1, v, t, fc, ov);
    lit("fullpop_tag", 32'(t), 32'd32);
    cyc(1'b0, 6'd0, 6'd0, 1'b1, v, t, fc, ov);
    lit("fullpop_count", 32'(fc), 32'd32);
    lit("fullpop_ovf", 32'(ov), 32'd1);
    for (int i = 0; i < 31; i++) cyc(1'b1, 6'd0, 6'd0, 1'b1, v, t, fc, ov);
    cyc(1'b1, 6'd0, 6'd0, 1'b1, v, t, fc, ov);
    lit("fullpop_kept", 32'(t), 32'd20);

    // Reset mid-stream discards that cycle's traffic.
    cyc(1'b1, 6'd3, 6'd4, 1'b1, v, t, fc, ov);
    cyc(1'b1, 6'd11, 6'd12, 1'b0, v, t, fc, ov);
    cyc(1'b0, 6'd0, 6'd0, 1'b1, v, t, fc, ov);
    lit("midrst_count", 32'(fc), 32'd32);
    lit("midrst_tag", 32'(t), 32'd32);
    lit("midrst_ovf", 32'(ov), 32'd0);

    // Random traffic alternating drain-heavy and fill-heavy phases.
    for (int p = 0; p < 8; p++) begin
      for (int n = 0; n < 300; n++) begin
        logic       rq, rs;
        logic [5:0] f1, f2;
        int         fpct;
        fpct = (p % 2 == 0) ? 25 : 80;
        rq = ($urandom_range(0, 99) < ((p % 2 == 0) ? 85 : 20));
        f1 = ($urandom_range(0, 99) < fpct) ? 6'($urandom_range(1, 63)) : 6'd0;
        f2 = ($urandom_range(0, 99) < fpct) ? 6'($urandom_range(1, 63)) : 6'd0;
        rs = ($urandom_range(0, 199) != 0);
        cyc(rq, f1, f2, rs, v, t, fc, ov);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phys_free_list.md
# phys_free_list

Physical-register free-list allocator for the out-of-order RISC-V core. It owns the pool of unmapped 6-bit physical tags and hands one tag per cycle to Rename for a new destination mapping. It reclaims up to two retired tags per cycle from the commit stage, in the same tag encoding as Rename's `freed_tag_1/2`. Rename stalls on its `alloc_valid`.

## Interface
- `TAG_W`, 6: physical tag width (64 physical registers).
- `NUM_ARCH`, 32: architectural registers; tags 0..NUM_ARCH-1 are mapped at reset.
- `DEPTH`, 32: free-list capacity, equal to 2^TAG_W − NUM_ARCH.
- `clk`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `alloc_req`  input  1  Rename needs a tag this cycle (rd ≠ x0).
- `alloc_valid`  output  1  a tag is available this cycle.
- `alloc_tag`  output  TAG_W  tag granted when `alloc_req && alloc_valid`.
- `freed_tag_1`  input  TAG_W  retired tag; 0 = none.
- `freed_tag_2`  input  TAG_W  second retired tag; 0 = none.
- `free_count`  output  6  tags currently stored, 0..DEPTH.
- `overflow`  output  1  sticky; set when a push was dropped because the list was full.

## Operation
- Storage is a circular FIFO of DEPTH × TAG_W entries with a 5-bit `head`, a 5-bit `tail` and a 6-bit count. Pointers wrap modulo DEPTH.
- Reset (reset==0 at an edge): entry i = NUM_ARCH+i, head=0, tail=0, count=DEPTH, overflow=0. Reset overrides every other input in that cycle.
- Pop: `alloc_tag` = entry[head], driven combinationally from registered state. If `alloc_req && count≠0`, head advances by 1 at the edge.
- `alloc_valid` = (count≠0). `alloc_req` with count==0 is a stall: no state change from the request. Rename retries on the next cycle.
- Push: each nonzero freed tag is written at tail. `freed_tag_1` is written first, then `freed_tag_2`, and tail advances by the number written (0, 1 or 2). Tag 0 (x0) is never pushed.
- Full handling: push capacity is DEPTH − count + (pop this cycle ? 1 : 0). Pushes beyond capacity are dropped in order, `freed_tag_2` first. Any drop sets `overflow`, which only reset clears.
- Count next = count − pop + pushes. It never exceeds DEPTH and never goes below 0.
- The block does not check for duplicate frees; duplicate detection is the verifier's responsibility.

## Timing
- Allocation latency is 0 cycles: the tag is valid in the same cycle as the request, and the consumed entry is gone after the edge.
- Free-to-allocate latency is 1 cycle: a tag pushed at edge N is allocatable in cycle N+1 (base build).
- Pop and push in the same cycle are both honoured. When count==1, the popped entry is the old head; pushed tags land behind it.
- Outputs after reset: `alloc_valid`=1, `alloc_tag`=NUM_ARCH (32), `free_count`=32, `overflow`=0.
- Reset asserted mid-operation discards all in-flight frees and allocations. The list restarts from the reset image on the next cycle.

## Configuration
- `FREELIST_BYPASS_EN` defined: when count==0 and `freed_tag_1`≠0, `alloc_valid`=1 and `alloc_tag`=`freed_tag_1`.
  - If `alloc_req` is also high, `freed_tag_1` is consumed directly and is not pushed; only `freed_tag_2` is pushed.
  - If `alloc_req` is low, `freed_tag_1` is pushed normally.
- `FREELIST_BYPASS_EN` undefined: count==0 forces `alloc_valid`=0 regardless of the freed tags. Frees are always pushed, and the tag is granted no earlier than the next cycle.

## Test plan
- Reset, then `alloc_req`=1 for 32 cycles -> tags 32,33,…,63 granted in order. `alloc_valid`=0 on cycle 33 and `free_count`=0.
- From empty, free (40, 7) in one cycle -> next cycle `free_count`=2. Two allocs return 40 then 7.
- Free 5 alone via `freed_tag_2` with `freed_tag_1`=0 -> exactly one push, and 5 is allocated next.
- With count==1 (head=50), alloc while freeing (9, 12) -> 50 granted, `free_count`=2, later allocs return 9 then 12.
- From full (count=32), free (20, 21) with no alloc -> both dropped, `overflow`=1, `free_count`=32. With alloc the same cycle instead -> 20 kept, 21 dropped, `overflow`=1.
- Empty list, alloc + free (33, 34) in one cycle:
  - With `FREELIST_BYPASS_EN`: 33 granted the same cycle, `free_count`=1.
  - Without it: no grant, `free_count`=2.
  - Then assert reset mid-stream -> the reset image is restored next cycle.
